// File: rtl/up_down_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// up_down_sweep_ctrl_pkg
//
// Shared definitions for the up/down sweep controller and its counter:
//   - default counter and half-sweep counter widths
//   - direction encodings matching the up_down input of up_down_counter
//   - sweep state enumeration
// -----------------------------------------------------------------------------
package up_down_sweep_ctrl_pkg;

    localparam int CNT_WIDTH_DEF = 3;
    localparam int SWP_WIDTH_DEF = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } sweep_state_t;

endpackage : up_down_sweep_ctrl_pkg

// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
//
// Free-running up/down counter with synchronous load and no enable.
// On every rising edge: load=1 takes counter_in, otherwise the count
// moves by one in the direction given by up_down (1 = up).
//
// Ports:
//   clk         in   clock
//   load        in   load strobe
//   up_down     in   count direction, 1 = up
//   counter_in  in   load value
//   counter_out out  current count
// -----------------------------------------------------------------------------
module up_down_counter #(
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 up_down,
    input  logic [CNT_WIDTH-1:0] counter_in,
    output logic [CNT_WIDTH-1:0] counter_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = counter_in;
        end else if (up_down) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign counter_out = count_q;

endmodule : up_down_counter

// File: rtl/up_down_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// up_down_sweep_ctrl
//
// Sequencer that makes an external up_down_counter sweep lo -> hi -> lo ...
// for a programmed number of half-sweeps (or continuously when the count is
// zero) and parks the counter with a continuous load whenever idle, since the
// counter itself has no enable.
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle request, begins a sweep when idle
//   abort        in   one-cycle request, terminates an active sweep
//   lo_bound     in   lower sweep bound (unsigned)
//   hi_bound     in   upper sweep bound (unsigned)
//   num_sweeps   in   half-sweeps to run, 0 = continuous
//   counter_out  in   feedback from the counter
//   load         out  counter load strobe
//   up_down      out  counter direction, 1 = up
//   counter_in   out  counter load value (park value while idle)
//   busy         out  sweep active
//   done         out  one-cycle pulse on normal completion
//   cfg_err      out  one-cycle pulse when a start is rejected (lo >= hi)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module up_down_sweep_ctrl
    import up_down_sweep_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int SWP_WIDTH = SWP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] lo_bound,
    input  logic [CNT_WIDTH-1:0] hi_bound,
    input  logic [SWP_WIDTH-1:0] num_sweeps,
    input  logic [CNT_WIDTH-1:0] counter_out,
    output logic                 load,
    output logic                 up_down,
    output logic [CNT_WIDTH-1:0] counter_in,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [SWP_WIDTH-1:0] SWP_ONE  = {{(SWP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SWP_WIDTH-1:0] SWP_ZERO = '0;

    // Control state
    sweep_state_t         state_q,      state_d;
    logic                 load_q,       load_d;
    logic                 up_down_q,    up_down_d;
    logic [CNT_WIDTH-1:0] counter_in_q, counter_in_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 cfg_err_q,    cfg_err_d;
    logic [SWP_WIDTH-1:0] hs_cnt_q,     hs_cnt_d;

    // Captured sweep configuration (only meaningful after a start)
    logic [CNT_WIDTH-1:0] lo_q,  lo_d;
    logic [CNT_WIDTH-1:0] hi_q,  hi_d;
    logic [SWP_WIDTH-1:0] num_q, num_d;

    logic [SWP_WIDTH-1:0] hs_next;
    logic                 continuous;
    logic                 last_half;
    logic                 at_turn_up;
    logic                 at_turn_down;

    assign hs_next    = hs_cnt_q + SWP_ONE;
    assign continuous = (num_q == SWP_ZERO);
    assign last_half  = !continuous && (hs_next == num_q);

    // The counter moves one step per edge, so turning around when it is one
    // step short of a bound makes it dwell exactly one cycle on that bound.
    assign at_turn_up   = (counter_out == (hi_q - CNT_ONE));
    assign at_turn_down = (counter_out == (lo_q + CNT_ONE));

    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        up_down_d    = up_down_q;
        counter_in_d = counter_in_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        hs_cnt_d     = hs_cnt_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        num_d        = num_q;

        case (state_q)
            ST_IDLE: begin
                // Keep reloading the park value so the counter cannot drift.
                load_d = 1'b1;
                busy_d = 1'b0;
                if (start && !abort) begin
                    if (lo_bound < hi_bound) begin
                        lo_d         = lo_bound;
                        hi_d         = hi_bound;
                        num_d        = num_sweeps;
                        hs_cnt_d     = SWP_ZERO;
                        counter_in_d = lo_bound;
                        up_down_d    = DIR_UP;
                        busy_d       = 1'b1;
                        state_d      = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                // counter_out still shows the old park value here; the load
                // of lo lands on this edge, so counting starts next cycle.
                load_d  = 1'b0;
                state_d = ST_UP;
            end

            ST_UP: begin
                if (at_turn_up) begin
                    up_down_d = DIR_DOWN;
                    state_d   = ST_DOWN;
                    if (!continuous) begin
                        hs_cnt_d = hs_next;
                    end
                    if (last_half) begin
                        load_d       = 1'b1;
                        counter_in_d = hi_q;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end

            ST_DOWN: begin
                if (at_turn_down) begin
                    up_down_d = DIR_UP;
                    state_d   = ST_UP;
                    if (!continuous) begin
                        hs_cnt_d = hs_next;
                    end
                    if (last_half) begin
                        load_d       = 1'b1;
                        counter_in_d = lo_q;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end

            default: begin
                load_d       = 1'b1;
                counter_in_d = CNT_ZERO;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        // Abort wins over any turnaround or completion in the same cycle and
        // parks the counter at the captured lower bound.
        if (abort && (state_q != ST_IDLE)) begin
            load_d       = 1'b1;
            counter_in_d = lo_q;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            load_q       <= 1'b1;
            up_down_q    <= DIR_DOWN;
            counter_in_q <= CNT_ZERO;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            hs_cnt_q     <= SWP_ZERO;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            up_down_q    <= up_down_d;
            counter_in_q <= counter_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            hs_cnt_q     <= hs_cnt_d;
        end
    end

    // Configuration copies are pure data, written only when a sweep starts.
    always_ff @(posedge clk) begin
        lo_q  <= lo_d;
        hi_q  <= hi_d;
        num_q <= num_d;
    end

    assign load       = load_q;
    assign up_down    = up_down_q;
    assign counter_in = counter_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule : up_down_sweep_ctrl

// File: tb/tb_up_down_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_up_down_sweep_ctrl
//
// Closed-loop bench: up_down_sweep_ctrl drives an up_down_counter whose output
// is fed back. Directed vector table plus hand-written corner sequences.
// -----------------------------------------------------------------------------
module tb_up_down_sweep_ctrl;

    localparam int CW = 3;
    localparam int SW = 4;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] lo_bound;
    logic [CW-1:0] hi_bound;
    logic [SW-1:0] num_sweeps;
    logic [CW-1:0] counter_out;
    logic          load;
    logic          up_down;
    logic [CW-1:0] counter_in;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int n_checks;
    int n_fail;

    up_down_sweep_ctrl #(
        .CNT_WIDTH(CW),
        .SWP_WIDTH(SW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .lo_bound   (lo_bound),
        .hi_bound   (hi_bound),
        .num_sweeps (num_sweeps),
        .counter_out(counter_out),
        .load       (load),
        .up_down    (up_down),
        .counter_in (counter_in),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    up_down_counter #(
        .CNT_WIDTH(CW)
    ) u_cnt (
        .clk        (clk),
        .load       (load),
        .up_down    (up_down),
        .counter_in (counter_in),
        .counter_out(counter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          start;
        logic          abort;
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [SW-1:0] num;
        logic [CW-1:0] exp_cnt;
        logic          exp_busy;
        logic          exp_done;
        logic          exp_cerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic a,
                       input logic [CW-1:0] lo, input logic [CW-1:0] hi,
                       input logic [SW-1:0] n, input logic [CW-1:0] c,
                       input logic b, input logic d, input logic e);
        vec_t v;
        v.rst_n = r; v.start = s; v.abort = a;
        v.lo = lo; v.hi = hi; v.num = n;
        v.exp_cnt = c; v.exp_busy = b; v.exp_done = d; v.exp_cerr = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_d[21] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        lo_bound   = '0;
        hi_bound   = '0;
        num_sweeps = '0;

        // ---------------- vector table ----------------
        // reset, then idle parked at 0
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // lo=2 hi=5 num=2
        add(1, 1, 0, 2, 5, 2,  0, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  2, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  3, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  4, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  5, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  4, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  3, 1, 0, 0);
        add(1, 0, 0, 2, 5, 2,  2, 0, 1, 0);
        add(1, 0, 0, 2, 5, 2,  2, 0, 0, 0);
        add(1, 0, 0, 2, 5, 2,  2, 0, 0, 0);
        // lo=3 hi=4 num=3: ping-pong
        add(1, 1, 0, 3, 4, 3,  2, 1, 0, 0);
        add(1, 0, 0, 3, 4, 3,  3, 1, 0, 0);
        add(1, 0, 0, 3, 4, 3,  4, 1, 0, 0);
        add(1, 0, 0, 3, 4, 3,  3, 1, 0, 0);
        add(1, 0, 0, 3, 4, 3,  4, 0, 1, 0);
        add(1, 0, 0, 3, 4, 3,  4, 0, 0, 0);
        add(1, 0, 0, 3, 4, 3,  4, 0, 0, 0);
        // rejected configurations keep park value 4
        add(1, 1, 0, 5, 5, 1,  4, 0, 0, 1);
        add(1, 0, 0, 5, 5, 1,  4, 0, 0, 0);
        add(1, 1, 0, 6, 2, 1,  4, 0, 0, 1);
        add(1, 0, 0, 6, 2, 1,  4, 0, 0, 0);
        // start together with abort while idle is ignored
        add(1, 1, 1, 1, 6, 2,  4, 0, 0, 0);
        add(1, 0, 0, 1, 6, 2,  4, 0, 0, 0);
        // lo=0 hi=7 continuous, abort after 12 cycles
        add(1, 1, 0, 0, 7, 0,  4, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  0, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  1, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  2, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  3, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  4, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  5, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  6, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  7, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  6, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  5, 1, 0, 0);
        add(1, 0, 0, 0, 7, 0,  4, 1, 0, 0);
        add(1, 0, 1, 0, 7, 0,  3, 0, 0, 0);
        add(1, 0, 0, 0, 7, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 7, 0,  0, 0, 0, 0);

        // reset values of every output
        tick();
        check("rst_load",       0, load,       1);
        check("rst_counter_in", 0, counter_in, 0);
        check("rst_up_down",    0, up_down,    0);
        check("rst_busy",       0, busy,       0);
        check("rst_done",       0, done,       0);
        check("rst_cfg_err",    0, cfg_err,    0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n    = vecs[i].rst_n;
            start      = vecs[i].start;
            abort      = vecs[i].abort;
            lo_bound   = vecs[i].lo;
            hi_bound   = vecs[i].hi;
            num_sweeps = vecs[i].num;
            tick();
            check("vec_cnt",  i, counter_out, vecs[i].exp_cnt);
            check("vec_busy", i, busy,        vecs[i].exp_busy);
            check("vec_done", i, done,        vecs[i].exp_done);
            check("vec_cerr", i, cfg_err,     vecs[i].exp_cerr);
        end
        start = 1'b0;
        abort = 1'b0;

        // ------- mid-sweep start and config changes are ignored -------
        lo_bound   = 3'd1;
        hi_bound   = 3'd6;
        num_sweeps = 4'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("mid_busy_start", 0, busy, 1);
        for (int k = 0; k < 21; k++) begin
            if (k == 1) begin
                start      = 1'b1;
                lo_bound   = 3'd0;
                hi_bound   = 3'd7;
                num_sweeps = 4'd1;
            end
            if (k == 2) start = 1'b0;
            if (k == 4) hi_bound = 3'd3;
            tick();
            check("mid_cnt",  k, counter_out, exp_d[k]);
            check("mid_busy", k, busy, (k < 20) ? 1 : 0);
            check("mid_done", k, done, (k == 20) ? 1 : 0);
        end
        tick();
        check("mid_hold_cnt",  0, counter_out, 1);
        check("mid_hold_done", 0, done, 0);

        // ------- reset asserted in the middle of a sweep -------
        lo_bound   = 3'd1;
        hi_bound   = 3'd6;
        num_sweeps = 4'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("rst_mid_pre_cnt",  0, counter_out, 4);
        check("rst_mid_pre_busy", 0, busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_load",       0, load,       1);
        check("rst_mid_counter_in", 0, counter_in, 0);
        check("rst_mid_up_down",    0, up_down,    0);
        check("rst_mid_busy",       0, busy,       0);
        check("rst_mid_done",       0, done,       0);
        tick();
        check("rst_mid_cnt", 0, counter_out, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("rst_mid_after_cnt",  0, counter_out, 0);
        check("rst_mid_after_busy", 0, busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_up_down_sweep_ctrl
